multicycle_controller: RTL and testbench

- Multi-cycle control FSM that sequences the shared MIPS datapath (register file, ALU, sign extension, PC) over several clocks per instruction.
- Uses one unified instruction/data memory port, guarded by a ready handshake and a timeout.
- Sits beside the datapath in the CPU top level, replacing single-cycle decode.
- Drives the mux selects, write enables and ALU control. Reports retired-instruction count, illegal opcodes and memory timeouts.

---
 rtl/mc_pkg.sv | 57 +++++
 rtl/mc_alu_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 267 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// opcode/funct constants, ALU control codes and datapath mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_ERROR  = 4'd12
  } state_t;

  // Selects how mc_alu_decoder derives alucontrol.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decoder. The FSM either forces ADD/SUB or lets
// the R-type funct field pick the operation; unknown funct is flagged.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        illegal
);

  // Map ALU-op override or funct field to an ALU control code
  always_comb begin
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: illegal    = 1'b1;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM driving the shared datapath through a single
// memory port with a ready handshake and a bounded wait.
// Optional feature: define MC_BNE_EN to decode bne (op 000101) as a branch
// with an inverted zero test; otherwise 000101 is an illegal opcode.
// Control outputs are decoded from the state register so that mem_ready can
// qualify irwrite/pcen within the same cycle; reset gates them to zero
// immediately.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memread,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcen,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             ill_instr,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX);

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired_q;
  logic              err_q;
  logic              retire;
  logic              timeout;
  logic              ill_dec;
  logic              mem_state;
  logic              pcwrite;
  logic              branch;
  logic              bne_flag;
  aluop_t            aluop;
  logic [2:0]        dec_alu;
  logic              dec_illegal;

  mc_alu_decoder u_alu_dec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (dec_alu),
    .illegal    (dec_illegal)
  );

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  // Choose the ALU operation source for the current state
  always_comb begin
    aluop = ALUOP_ADD;
    case (state)
      S_BRANCH: aluop = ALUOP_SUB;
      S_EXEC:   aluop = ALUOP_FUNCT;
      default:  aluop = ALUOP_ADD;
    endcase
  end

  // Next-state logic, including memory timeout and retirement detection
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    timeout    = 1'b0;
    ill_dec    = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          next_state = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_ERROR;
          timeout    = 1'b1;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       next_state = S_BRANCH;
`endif
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default: begin
            next_state = S_FETCH;
            ill_dec    = 1'b1;
          end
        endcase
      end
      S_MEMADR: next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready) begin
          next_state = S_MEMWB;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_ERROR;
          timeout    = 1'b1;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_ERROR;
          timeout    = 1'b1;
        end
      end
      S_EXEC:   next_state = dec_illegal ? S_FETCH : S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_ERROR:  next_state = S_ERROR;
      default:  next_state = S_ERROR;
    endcase
  end

  // FSM state, memory wait counter, retired counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= next_state;
      if (mem_state && !mem_ready && !timeout) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef MC_BNE_EN
  logic bne_q;

  // Remember whether the decoded branch is bne so BRANCH inverts the zero test
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bne_q <= 1'b0;
    end else if (state == S_DECODE) begin
      bne_q <= (op == OP_BNE);
    end
  end

  assign bne_flag = bne_q;
`else
  assign bne_flag = 1'b0;
`endif

  // Moore decode of datapath controls; reset forces every control low at once
  always_comb begin
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    pcsrc      = PCSRC_ALU;
    alucontrol = ALU_AND;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (state)
      S_FETCH: begin
        memread    = 1'b1;
        alusrcb    = SRCB_FOUR;
        alucontrol = dec_alu;
        irwrite    = mem_ready;
        pcwrite    = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMM_SH2;
        alucontrol = dec_alu;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = dec_alu;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alucontrol = dec_alu;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        pcsrc      = PCSRC_ALUOUT;
        alucontrol = dec_alu;
        branch     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = dec_alu;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    pcen      = pcwrite | (branch & (zero ^ bne_flag));
    ill_instr = ill_dec | ((state == S_EXEC) & dec_illegal);
    if (reset) begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      ill_instr  = 1'b0;
    end
  end

  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction vector table
// feeding an expected-output queue, plus hand-written timeout/reset sequences.
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       op = 6'd0;
  logic [5:0]       funct = 6'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b1;
  logic             memread, memwrite, iord, irwrite, pcen, regwrite;
  logic             regdst, memtoreg, alusrca, ill_instr, err;
  logic [1:0]       alusrcb, pcsrc;
  logic [2:0]       alucontrol;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_MAX(15), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .memread    (memread),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .ill_instr  (ill_instr),
    .err        (err),
    .retired    (retired)
  );

  typedef struct {
    logic [16:0] w;
    logic        rdy;
    string       name;
  } exp_t;

  typedef struct {
    string            name;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             ret;
    int               n;
    logic [4:0][16:0] w;
  } vec_t;

  exp_t             exp_q[$];
  vec_t             vecs[16];
  int               n_vecs = 0;
  int               n_tests = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  logic [16:0] W_ZERO, W_FETCH, W_FWAIT, W_DECODE, W_DEC_ILL, W_MEMADR, W_MEMRD;
  logic [16:0] W_MEMWB, W_MEMWR, W_ALUWB, W_ADDIEX, W_ADDIWB, W_JUMP;

  // Control word: memread memwrite iord irwrite pcen regwrite regdst memtoreg
  //               alusrca alusrcb[2] pcsrc[2] alucontrol[3] ill_instr
  function automatic logic [16:0] mk(logic mr, logic mw, logic io, logic irw, logic pe,
                                     logic rw, logic rd, logic mtr, logic asa,
                                     logic [1:0] asb, logic [1:0] pcs, logic [2:0] alu,
                                     logic ill);
    return {mr, mw, io, irw, pe, rw, rd, mtr, asa, asb, pcs, alu, ill};
  endfunction

  function automatic logic [16:0] w_exec(logic [2:0] alu);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, alu, 0);
  endfunction

  function automatic logic [16:0] w_branch(logic pe);
    return mk(0, 0, 0, 0, pe, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
  endfunction

  function automatic logic [16:0] dut_cw();
    return {memread, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
            alusrca, alusrcb, pcsrc, alucontrol, ill_instr};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(logic [16:0] w, logic rdy, string name);
    exp_t e;
    e.w    = w;
    e.rdy  = rdy;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Each expected entry covers one clock: drive mem_ready at negedge, compare, step.
  task automatic run_q();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      mem_ready = e.rdy;
      #1;
      check(e.name, 32'(dut_cw()), 32'(e.w));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_ret = '0;
  endtask

  task automatic add_vec(string name, logic [5:0] o, logic [5:0] f, logic z, logic ret,
                         int n, logic [16:0] a, logic [16:0] b, logic [16:0] c,
                         logic [16:0] d, logic [16:0] e);
    vecs[n_vecs].name  = name;
    vecs[n_vecs].op    = o;
    vecs[n_vecs].funct = f;
    vecs[n_vecs].zero  = z;
    vecs[n_vecs].ret   = ret;
    vecs[n_vecs].n     = n;
    vecs[n_vecs].w[0]  = a;
    vecs[n_vecs].w[1]  = b;
    vecs[n_vecs].w[2]  = c;
    vecs[n_vecs].w[3]  = d;
    vecs[n_vecs].w[4]  = e;
    n_vecs++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    W_ZERO    = '0;
    W_FETCH   = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    W_FWAIT   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    W_DECODE  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0);
    W_DEC_ILL = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1);
    W_MEMADR  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
    W_MEMRD   = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    W_MEMWB   = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    W_MEMWR   = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    W_ALUWB   = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    W_ADDIEX  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
    W_ADDIWB  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    W_JUMP    = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);

    add_vec("lw",     6'b100011, 6'd0, 0, 1, 5, W_FETCH, W_DECODE, W_MEMADR, W_MEMRD, W_MEMWB);
    add_vec("sw",     6'b101011, 6'd0, 0, 1, 4, W_FETCH, W_DECODE, W_MEMADR, W_MEMWR, W_ZERO);
    add_vec("add",    6'b000000, 6'b100000, 0, 1, 4, W_FETCH, W_DECODE, w_exec(3'b010), W_ALUWB, W_ZERO);
    add_vec("sub",    6'b000000, 6'b100010, 0, 1, 4, W_FETCH, W_DECODE, w_exec(3'b110), W_ALUWB, W_ZERO);
    add_vec("and",    6'b000000, 6'b100100, 1, 1, 4, W_FETCH, W_DECODE, w_exec(3'b000), W_ALUWB, W_ZERO);
    add_vec("or",     6'b000000, 6'b100101, 0, 1, 4, W_FETCH, W_DECODE, w_exec(3'b001), W_ALUWB, W_ZERO);
    add_vec("slt",    6'b000000, 6'b101010, 0, 1, 4, W_FETCH, W_DECODE, w_exec(3'b111), W_ALUWB, W_ZERO);
    add_vec("beq_z1", 6'b000100, 6'd0, 1, 1, 3, W_FETCH, W_DECODE, w_branch(1), W_ZERO, W_ZERO);
    add_vec("beq_z0", 6'b000100, 6'd0, 0, 1, 3, W_FETCH, W_DECODE, w_branch(0), W_ZERO, W_ZERO);
    add_vec("addi",   6'b001000, 6'd0, 0, 1, 4, W_FETCH, W_DECODE, W_ADDIEX, W_ADDIWB, W_ZERO);
    add_vec("j",      6'b000010, 6'd0, 0, 1, 3, W_FETCH, W_DECODE, W_JUMP, W_ZERO, W_ZERO);
    add_vec("ill_op", 6'b111111, 6'd0, 0, 0, 2, W_FETCH, W_DEC_ILL, W_ZERO, W_ZERO, W_ZERO);
`ifdef MC_BNE_EN
    add_vec("bne_z0", 6'b000101, 6'd0, 0, 1, 3, W_FETCH, W_DECODE, w_branch(1), W_ZERO, W_ZERO);
    add_vec("bne_z1", 6'b000101, 6'd0, 1, 1, 3, W_FETCH, W_DECODE, w_branch(0), W_ZERO, W_ZERO);
`else
    add_vec("op05",   6'b000101, 6'd0, 0, 0, 2, W_FETCH, W_DEC_ILL, W_ZERO, W_ZERO, W_ZERO);
`endif

    // Reset state: controls gated low even with mem_ready high in FETCH
    @(negedge clk);
    #1;
    check("reset outputs", 32'(dut_cw()), 32'd0);
    check("reset retired", 32'(retired), 32'd0);
    check("reset err", 32'(err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Table pass 0: memory always ready; pass 1: two FETCH stall cycles first.
    // Two passes retire more than 16 instructions, so the 4-bit counter wraps.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < n_vecs; i++) begin
        check($sformatf("%s p%0d retired", vecs[i].name, pass), 32'(retired), 32'(exp_ret));
        op    = vecs[i].op;
        funct = vecs[i].funct;
        zero  = vecs[i].zero;
        for (int s = 0; s < pass * 2; s++) push(W_FWAIT, 1'b0, "fetch stall");
        for (int k = 0; k < vecs[i].n; k++)
          push(vecs[i].w[k], 1'b1, $sformatf("%s p%0d c%0d", vecs[i].name, pass, k));
        run_q();
        if (vecs[i].ret) exp_ret = exp_ret + 1'b1;
      end
    end
    check("retired after table", 32'(retired), 32'(exp_ret));

    // Illegal funct: one-cycle ill_instr in EXEC, no writeback, no retire
    op = 6'b000000;
    funct = 6'b111111;
    push(W_FETCH, 1'b1, "illfn fetch");
    push(W_DECODE, 1'b1, "illfn decode");
    run_q();
    @(negedge clk);
    #1;
    check("illfn ill_instr", 32'(ill_instr), 32'd1);
    check("illfn regwrite", 32'(regwrite), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("illfn pulse end", 32'(ill_instr), 32'd0);
    check("illfn back in fetch", 32'(dut_cw()), 32'(W_FWAIT));
    check("illfn retired", 32'(retired), 32'(exp_ret));
    @(posedge clk);
    #1;

    // Reset asserted mid-cycle during a stalled MEMWR
    op = 6'b101011;
    funct = 6'd0;
    push(W_FETCH, 1'b1, "rst_sw fetch");
    push(W_DECODE, 1'b1, "rst_sw decode");
    push(W_MEMADR, 1'b1, "rst_sw memadr");
    run_q();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("rst_sw memwrite before", 32'(memwrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_sw memwrite async", 32'(memwrite), 32'd0);
    check("rst_sw outputs async", 32'(dut_cw()), 32'd0);
    check("rst_sw retired cleared", 32'(retired), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_ret = '0;
    @(negedge clk);
    #1;
    check("rst_sw fetch after", 32'(dut_cw()), 32'(W_FWAIT));
    check("rst_sw retired after", 32'(retired), 32'd0);
    @(posedge clk);
    #1;

    // Timeout in FETCH: 16 cycles without ready, then ERROR ignores mem_ready
    do_reset();
    op = 6'b001000;
    for (int c = 0; c < 15; c++) push(W_FWAIT, 1'b0, $sformatf("to wait %0d", c));
    run_q();
    check("to err before limit", 32'(err), 32'd0);
    push(W_FWAIT, 1'b0, "to wait 15");
    for (int c = 0; c < 3; c++) push(W_ZERO, 1'b1, $sformatf("to error %0d", c));
    run_q();
    check("to err sticky", 32'(err), 32'd1);
    check("to retired", 32'(retired), 32'd0);

    // Ready arriving on the 16th waiting cycle wins over the timeout
    do_reset();
    check("rdy16 err cleared", 32'(err), 32'd0);
    op = 6'b001000;
    for (int c = 0; c < 15; c++) push(W_FWAIT, 1'b0, $sformatf("rdy16 wait %0d", c));
    push(W_FETCH, 1'b1, "rdy16 fetch");
    push(W_DECODE, 1'b1, "rdy16 decode");
    push(W_ADDIEX, 1'b1, "rdy16 addiex");
    push(W_ADDIWB, 1'b1, "rdy16 addiwb");
    run_q();
    check("rdy16 err", 32'(err), 32'd0);
    check("rdy16 retired", 32'(retired), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
